branch_predict_resolve: RTL and testbench
=========================================

BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 64: number of branch-history entries; power of two, at least 2.
REQ-003 SHALL have parameter CTR_BITS, default 2: width of each saturating counter, at least 1.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports named as listed below.
REQ-005 SHALL have these ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  prediction for fetch_pc (combinational).
- res_valid  in  1  resolve request valid.
- res_branch  in  1  instruction is a conditional branch.
- res_funct3  in  3  branch condition code.
- res_rs1  in  XLEN  first operand.
- res_rs2  in  XLEN  second operand.
- res_pc  in  XLEN  branch PC.
- res_target  in  XLEN  taken target.
- res_pred  in  1  prediction made at fetch.
- out_valid  out  1  registered result valid.
- out_taken  out  1  registered actual outcome.
- out_mispredict  out  1  registered mispredict flag.
- out_redirect_pc  out  XLEN  registered correct next PC.
- out_illegal  out  1  registered illegal-funct3 flag.

Function
REQ-006 SHALL index the BHT with idx = pc[log2(BHT_DEPTH)+1:2].
REQ-007 SHALL drive pred_taken as the MSB of BHT[idx(fetch_pc)], with no registered delay.
REQ-008 SHALL evaluate the condition when res_valid && res_branch, using funct3:
- 000 = equal; 001 = not equal.
- 100 = signed less-than; 101 = signed greater-or-equal.
- 110 = unsigned less-than; 111 = unsigned greater-or-equal.
REQ-009 SHALL treat funct3 010 or 011 as illegal: taken = 0, no BHT update, out_illegal = 1.
REQ-010 SHALL produce outputs exactly one cycle after the accepted request: out_valid = 1, out_taken, out_mispredict = (taken != res_pred), out_redirect_pc = taken ? res_target : res_pc + 4 (modulo 2^XLEN).
REQ-011 SHALL, when res_valid && !res_branch, output out_valid = 1, out_taken = 0, out_mispredict = 0, out_illegal = 0, out_redirect_pc = res_pc + 4, and leave the BHT unchanged.
REQ-012 SHALL drive out_valid = 0 in the cycle following any cycle with res_valid = 0; the other out_* outputs are then don't-care but must not be X.
REQ-013 SHALL update BHT[idx(res_pc)] at the clock edge of a legal resolve: increment saturating at 2^CTR_BITS-1 if taken, otherwise decrement saturating at 0.
REQ-014 SHALL, when lookup and update hit the same index in the same cycle, return the pre-update value on pred_taken (no bypass).
REQ-015 SHALL accept one request per cycle, back-to-back, with no stall.

Reset
REQ-016 SHALL, while rst_n is low, asynchronously set every BHT entry to 2^(CTR_BITS-1)-1 (weakly not-taken).
REQ-017 SHALL, while rst_n is low, set out_valid, out_taken, out_mispredict and out_illegal to 0 and out_redirect_pc to 0.
REQ-018 SHALL, when reset occurs mid-stream, discard the in-flight result: no out_valid in the cycle after deassertion.

Configuration
REQ-019 SHALL, with macro BRANCH_PREDICT_STATS_EN defined, add outputs stat_branches [31:0] and stat_mispredicts [31:0]:
- stat_branches counts legal resolves; stat_mispredicts counts mispredicting legal resolves.
- Both saturate at 0xFFFFFFFF and reset to 0.
REQ-020 SHALL, without BRANCH_PREDICT_STATS_EN, omit both ports and all related logic.

Structure
REQ-021 SHALL place the funct3 encodings (BEQ, BNE, BLT, BGE, BLTU, BGEU) as constants in the shared package, with no local duplicates.
REQ-022 SHALL contain one sub-module, branch_cond_eval: combinational funct3/rs1/rs2 to taken/illegal.
REQ-023 SHALL keep the BHT and output registers in the top level.

Verification
REQ-024 SHALL cover: after reset, fetch_pc = 0x100 -> pred_taken = 0; BEQ rs1 = rs2 = 5, res_pred = 0 -> next cycle out_taken = 1, out_mispredict = 1, out_redirect_pc = res_target.
REQ-025 SHALL cover: two taken resolves at pc = 0x40 -> pred_taken(0x40) = 1; a third taken resolve keeps the counter at 3; one not-taken -> still 1; a second not-taken -> 0.
REQ-026 SHALL cover: BLT rs1 = 0xFFFFFFFF, rs2 = 1 -> taken; BLTU with the same operands -> not taken, redirect_pc = res_pc + 4.
REQ-027 SHALL cover: funct3 = 010 -> out_illegal = 1, out_taken = 0, BHT entry unchanged.
REQ-028 SHALL cover: same-cycle lookup and update at index 5 -> pred_taken shows the old value, the new value appears the next cycle; res_pc = 0xFFFFFFFC not taken -> out_redirect_pc = 0.
REQ-029 SHALL cover, with BRANCH_PREDICT_STATS_EN: 10 resolves with 3 mispredicts -> stat_branches = 10, stat_mispredicts = 3; rst_n pulse mid-stream -> both counters 0 and out_valid = 0.

Source files
------------

// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch predictor / resolver: funct3 encodings
// and the registered result flag bundle.
package branch_predict_resolve_pkg;

  typedef logic [2:0] funct3_t;

  localparam funct3_t F3_BEQ  = 3'b000;
  localparam funct3_t F3_BNE  = 3'b001;
  localparam funct3_t F3_BLT  = 3'b100;
  localparam funct3_t F3_BGE  = 3'b101;
  localparam funct3_t F3_BLTU = 3'b110;
  localparam funct3_t F3_BGEU = 3'b111;

  typedef struct packed {
    logic valid;
    logic taken;
    logic mispredict;
    logic illegal;
  } res_flags_t;

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Resolve request / result bundle of branch_predict_resolve; the master
// issues requests and consumes results, the slave is the resolver.
interface branch_predict_resolve_if #(
  parameter int XLEN = 32
);
  logic            res_valid;
  logic            res_branch;
  logic [2:0]      res_funct3;
  logic [XLEN-1:0] res_rs1;
  logic [XLEN-1:0] res_rs2;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] res_target;
  logic            res_pred;
  logic            out_valid;
  logic            out_taken;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_illegal;

  modport master (
    output res_valid, res_branch, res_funct3, res_rs1, res_rs2,
           res_pc, res_target, res_pred,
    input  out_valid, out_taken, out_mispredict, out_redirect_pc, out_illegal
  );

  modport slave (
    input  res_valid, res_branch, res_funct3, res_rs1, res_rs2,
           res_pc, res_target, res_pred,
    output out_valid, out_taken, out_mispredict, out_redirect_pc, out_illegal
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: funct3 + operands -> taken,
// with funct3 codes 010/011 reported as illegal.
module branch_cond_eval
  import branch_predict_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  funct3_t         funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;

  assign rs1_s = $signed(rs1);
  assign rs2_s = $signed(rs2);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = (rs1_s <  rs2_s);
      F3_BGE:  taken = (rs1_s >= rs2_s);
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Bimodal branch predictor with a one-cycle branch resolver.
// Optional statistics counters are built when BRANCH_PREDICT_STATS_EN is defined.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_BITS  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic            res_branch,
  input  logic [2:0]      res_funct3,
  input  logic [XLEN-1:0] res_rs1,
  input  logic [XLEN-1:0] res_rs2,
  input  logic [XLEN-1:0] res_pc,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred,
  output logic            out_valid,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_illegal
`ifdef BRANCH_PREDICT_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic [CTR_BITS-1:0] bht_q [BHT_DEPTH];
  logic [CTR_BITS-1:0] bht_d [BHT_DEPTH];
  res_flags_t          flags_q, flags_d;
  logic [XLEN-1:0]     redirect_q, redirect_d;

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic [XLEN-1:0]  pc_plus4;
  logic             cond_taken;
  logic             cond_illegal;
  logic             taken;
  logic             upd_en;
  logic             unused_fetch_bits;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .funct3  (res_funct3),
    .rs1     (res_rs1),
    .rs2     (res_rs2),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign fetch_idx  = fetch_pc[IDX_W+1:2];
  assign pred_taken = bht_q[fetch_idx][CTR_BITS-1];

  assign unused_fetch_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

  always_comb begin
    res_idx  = res_pc[IDX_W+1:2];
    pc_plus4 = res_pc + XLEN'(4);
    taken    = res_branch && !cond_illegal && cond_taken;
    upd_en   = res_valid && res_branch && !cond_illegal;

    // Payload holds while idle so it never turns X once reset has been seen.
    flags_d       = flags_q;
    flags_d.valid = res_valid;
    redirect_d    = redirect_q;
    if (res_valid) begin
      flags_d.taken      = taken;
      flags_d.mispredict = res_branch && (taken != res_pred);
      flags_d.illegal    = res_branch && cond_illegal;
      redirect_d         = taken ? res_target : pc_plus4;
    end

    bht_d = bht_q;
    if (upd_en) begin
      bht_d[res_idx] = taken ? ctr_inc(bht_q[res_idx]) : ctr_dec(bht_q[res_idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CTR_INIT;
      end
      flags_q    <= '0;
      redirect_q <= '0;
    end else begin
      bht_q      <= bht_d;
      flags_q    <= flags_d;
      redirect_q <= redirect_d;
    end
  end

  assign out_valid       = flags_q.valid;
  assign out_taken       = flags_q.taken;
  assign out_mispredict  = flags_q.mispredict;
  assign out_illegal     = flags_q.illegal;
  assign out_redirect_pc = redirect_q;

`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (upd_en) begin
      if (stat_br_q != '1) stat_br_d = stat_br_q + 32'd1;
      if ((taken != res_pred) && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench for branch_predict_resolve: vector table plus hand
// sequences for counter saturation, same-index lookup/update and reset.
module tb_branch_predict_resolve;
  import branch_predict_resolve_pkg::*;

  localparam int XLEN      = 32;
  localparam int BHT_DEPTH = 64;
  localparam int CTR_BITS  = 2;
  localparam int CTR_INIT  = (1 << (CTR_BITS - 1)) - 1;
  localparam int CTR_MAX   = (1 << CTR_BITS) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            pred_taken;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  branch_predict_resolve_if #(.XLEN(XLEN)) bus ();

  always #5 clk = ~clk;

  branch_predict_resolve #(
    .XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .CTR_BITS(CTR_BITS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .res_valid       (bus.res_valid),
    .res_branch      (bus.res_branch),
    .res_funct3      (bus.res_funct3),
    .res_rs1         (bus.res_rs1),
    .res_rs2         (bus.res_rs2),
    .res_pc          (bus.res_pc),
    .res_target      (bus.res_target),
    .res_pred        (bus.res_pred),
    .out_valid       (bus.out_valid),
    .out_taken       (bus.out_taken),
    .out_mispredict  (bus.out_mispredict),
    .out_redirect_pc (bus.out_redirect_pc),
    .out_illegal     (bus.out_illegal)
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, tgt;
    logic        pred, br;
    logic        e_taken, e_mis, e_ill;
  } vec_t;

  typedef struct {
    logic        taken, mis, ill;
    logic [31:0] redir;
  } exp_t;

  exp_t sb[$];
  int   model[BHT_DEPTH];
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                              input logic br, input logic et, input logic em, input logic ei);
    vec_t v;
    v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.tgt = tgt;
    v.pred = pred; v.br = br; v.e_taken = et; v.e_mis = em; v.e_ill = ei;
    return v;
  endfunction

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(BHT_DEPTH));
  endfunction

  function automatic logic model_msb(input logic [31:0] pc);
    return logic'((model[midx(pc)] >> (CTR_BITS - 1)) & 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_DEPTH; i++) model[i] = CTR_INIT;
    sb.delete();
  endtask

  task automatic collect();
    exp_t e;
    check("out_valid", bus.out_valid, 1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("out_taken", bus.out_taken, e.taken);
      check("out_mispredict", bus.out_mispredict, e.mis);
      check("out_illegal", bus.out_illegal, e.ill);
      check("out_redirect_pc", bus.out_redirect_pc, e.redir);
    end
  endtask

  // Drive one request with fetch_pc aliased to it, check the pre-update
  // prediction, then collect the result one cycle later.
  task automatic do_vec(input vec_t v);
    exp_t e;
    int   i;
    fetch_pc       = v.pc;
    bus.res_valid  = 1'b1;
    bus.res_branch = v.br;
    bus.res_funct3 = v.f3;
    bus.res_rs1    = v.rs1;
    bus.res_rs2    = v.rs2;
    bus.res_pc     = v.pc;
    bus.res_target = v.tgt;
    bus.res_pred   = v.pred;
    e.taken = v.e_taken;
    e.mis   = v.e_mis;
    e.ill   = v.e_ill;
    e.redir = v.e_taken ? v.tgt : v.pc + 32'd4;
    sb.push_back(e);
    #1;
    check("pred_taken_pre", pred_taken, model_msb(v.pc));
    if (v.br && !v.e_ill) begin
      i = midx(v.pc);
      if (v.e_taken) model[i] = (model[i] == CTR_MAX) ? CTR_MAX : model[i] + 1;
      else           model[i] = (model[i] == 0) ? 0 : model[i] - 1;
    end
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    collect();
  endtask

  task automatic idle();
    bus.res_valid = 1'b0;
    @(posedge clk);
    #1;
    check("out_valid_idle", bus.out_valid, 0);
  endtask

  task automatic peek_pred(input string name, input logic [31:0] pc, input logic exp);
    fetch_pc = pc;
    #1;
    check(name, pred_taken, exp);
  endtask

  initial begin
    bus.res_valid = 1'b0; bus.res_branch = 1'b0; bus.res_funct3 = '0;
    bus.res_rs1 = '0; bus.res_rs2 = '0; bus.res_pc = '0; bus.res_target = '0; bus.res_pred = 1'b0;

    tbl[0]  = mk(F3_BEQ,  32'd5, 32'd5, 32'h208, 32'h1000, 0, 1, 1, 1, 0);
    tbl[1]  = mk(F3_BEQ,  32'd5, 32'd6, 32'h218, 32'h1100, 0, 1, 0, 0, 0);
    tbl[2]  = mk(F3_BNE,  32'd5, 32'd6, 32'h228, 32'h1200, 1, 1, 1, 0, 0);
    tbl[3]  = mk(F3_BNE,  32'd7, 32'd7, 32'h238, 32'h1300, 1, 1, 0, 1, 0);
    tbl[4]  = mk(F3_BLT,  32'hFFFFFFFF, 32'd1, 32'h248, 32'h1400, 0, 1, 1, 1, 0);
    tbl[5]  = mk(F3_BLTU, 32'hFFFFFFFF, 32'd1, 32'h258, 32'h1500, 0, 1, 0, 0, 0);
    tbl[6]  = mk(F3_BGE,  32'd1, 32'hFFFFFFFF, 32'h268, 32'h1600, 1, 1, 1, 0, 0);
    tbl[7]  = mk(F3_BGE,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h278, 32'h1700, 0, 1, 1, 1, 0);
    tbl[8]  = mk(F3_BGEU, 32'd1, 32'hFFFFFFFF, 32'h288, 32'h1800, 0, 1, 0, 0, 0);
    tbl[9]  = mk(F3_BLTU, 32'd1, 32'hFFFFFFFF, 32'h298, 32'h1900, 1, 1, 1, 0, 0);
    tbl[10] = mk(3'b010,  32'd5, 32'd5, 32'h2A8, 32'h1A00, 0, 1, 0, 0, 1);
    tbl[11] = mk(3'b011,  32'd5, 32'd5, 32'h2B8, 32'h1B00, 0, 1, 0, 0, 1);
    tbl[12] = mk(F3_BEQ,  32'd5, 32'd5, 32'h2C8, 32'h1C00, 1, 0, 0, 0, 0);
    tbl[13] = mk(F3_BLTU, 32'd5, 32'd3, 32'hFFFFFFFC, 32'h1D00, 0, 1, 0, 0, 0);

    // Reset values
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_taken", bus.out_taken, 0);
    check("rst_out_mispredict", bus.out_mispredict, 0);
    check("rst_out_illegal", bus.out_illegal, 0);
    check("rst_out_redirect_pc", bus.out_redirect_pc, 0);
    peek_pred("rst_pred_0x100", 32'h100, 0);
    rst_n = 1'b1;
    idle();

    // Table vectors, back-to-back
    for (int i = 0; i < 14; i++) do_vec(tbl[i]);
    idle();

    // Counter training and saturation at pc 0x40
    do_vec(mk(F3_BEQ, 32'd1, 32'd1, 32'h40, 32'h80, 0, 1, 1, 1, 0));
    do_vec(mk(F3_BEQ, 32'd1, 32'd1, 32'h40, 32'h80, 0, 1, 1, 1, 0));
    peek_pred("train_two_taken", 32'h40, 1);
    do_vec(mk(F3_BEQ, 32'd1, 32'd1, 32'h40, 32'h80, 1, 1, 1, 0, 0));
    do_vec(mk(F3_BNE, 32'd1, 32'd1, 32'h40, 32'h80, 1, 1, 0, 1, 0));
    peek_pred("sat_then_one_nt", 32'h40, 1);
    do_vec(mk(F3_BNE, 32'd1, 32'd1, 32'h40, 32'h80, 1, 1, 0, 1, 0));
    peek_pred("second_nt", 32'h40, 0);

    // Illegal funct3 leaves a trained entry untouched
    do_vec(mk(F3_BEQ, 32'd2, 32'd2, 32'h80, 32'hC0, 0, 1, 1, 1, 0));
    peek_pred("ill_pre", 32'h80, 1);
    do_vec(mk(3'b010, 32'd2, 32'd3, 32'h80, 32'hC0, 0, 1, 0, 0, 1));
    peek_pred("ill_bht_unchanged", 32'h80, 1);

    // Same-index lookup and update at index 5: old value, then new
    peek_pred("idx5_before", 32'h14, 0);
    do_vec(mk(F3_BGEU, 32'd9, 32'd9, 32'h14, 32'h400, 0, 1, 1, 1, 0));
    peek_pred("idx5_after", 32'h14, 1);
    idle();

    // Reset mid-stream discards the in-flight result and clears the table
    fetch_pc = 32'h40;
    bus.res_valid = 1'b1; bus.res_branch = 1'b1; bus.res_funct3 = F3_BEQ;
    bus.res_rs1 = 32'd3; bus.res_rs2 = 32'd3; bus.res_pc = 32'h14; bus.res_pred = 1'b0;
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    peek_pred("midrst_bht_idx5", 32'h14, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();

`ifdef BRANCH_PREDICT_STATS_EN
    check("stat_br_reset", stat_branches, 0);
    check("stat_mis_reset", stat_mispredicts, 0);
    for (int i = 0; i < 10; i++) begin
      do_vec(mk(F3_BEQ, 32'd4, 32'd4, 32'h300, 32'h500, (i < 3) ? 1'b0 : 1'b1, 1, 1, (i < 3) ? 1'b1 : 1'b0, 0));
    end
    do_vec(mk(3'b011, 32'd4, 32'd4, 32'h300, 32'h500, 1, 1, 0, 1, 1));
    do_vec(mk(F3_BEQ, 32'd4, 32'd4, 32'h300, 32'h500, 1, 0, 0, 0, 0));
    check("stat_branches", stat_branches, 10);
    check("stat_mispredicts", stat_mispredicts, 3);
    bus.res_valid = 1'b1; bus.res_branch = 1'b1; bus.res_funct3 = F3_BEQ;
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("stat_br_midrst", stat_branches, 0);
    check("stat_mis_midrst", stat_mispredicts, 0);
    check("stat_midrst_out_valid", bus.out_valid, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
